occ_fetch_unit: RTL and testbench

- Responder to the search state controller: watches the controller's 3-bit `state` and serves the two Occ lookups.
- In GET_DATA_2 it fetches Occ(sym, k-1); in GET_DATA_3 it fetches Occ(sym, l).
- Each completed fetch raises `is_data_done_2` / `is_data_done_3` for one cycle, which advances the controller.
- Sits between the controller and the Occ table memory port.

---
 rtl/occ_fetch_unit.sv | 202 ++++++++++++++++++++
 tb/tb_occ_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/occ_fetch_unit.sv
// occ_fetch_unit: serves the two Occ lookups for the search state controller.
//   On entry to GET_DATA_2 it fetches Occ(sym, k-1) into occ_k.
//   On entry to GET_DATA_3 it fetches Occ(sym, l) into occ_l.
//   Each completed fetch pulses is_data_done_2 / is_data_done_3 for one cycle.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   state, k, l, sym          controller state, interval bounds, read symbol
//   mem_req/addr/gnt          Occ table request channel
//   mem_rvalid/rdata          Occ table response channel (one per grant, in order)
//   occ_k, occ_l              fetched counts
//   is_data_done_2/3          one-cycle completion pulses
// Optional feature: define OCC_CACHE_EN for a single-entry row cache.
module occ_fetch_unit #(
    parameter int unsigned POS_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         state,
    input  logic [POS_W-1:0]   k,
    input  logic [POS_W-1:0]   l,
    input  logic [1:0]         sym,
    output logic               mem_req,
    output logic [POS_W-1:0]   mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [4*CNT_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]   occ_k,
    output logic [CNT_W-1:0]   occ_l,
    output logic               is_data_done_2,
    output logic               is_data_done_3
);

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_GD2  = 3'b011;
    localparam logic [2:0] ST_GD3  = 3'b100;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_DRAIN} fsm_t;

    fsm_t               fsm_q;
    logic [2:0]         prev_state_q;
    logic               tgt_l_q;     // 0: fetch for occ_k, 1: fetch for occ_l
    logic               pend_q;      // entry edge seen while busy
    logic               mem_req_q;
    logic [POS_W-1:0]   mem_addr_q;
    logic [CNT_W-1:0]   occ_k_q;
    logic [CNT_W-1:0]   occ_l_q;
    logic               done2_q;
    logic               done3_q;

    logic               is_tgt_state;
    logic               entry;
    logic               launch;
    logic               launch_l;
    logic               k_zero;
    logic [POS_W-1:0]   launch_addr;
    logic [2:0]         tgt_state;
    logic               abort;
    logic [CNT_W-1:0]   rd_field;

    // Launch/abort decode
    always_comb begin
        is_tgt_state = (state == ST_GD2) || (state == ST_GD3);
        entry        = is_tgt_state && (state != prev_state_q);
        launch       = (fsm_q == S_IDLE) && is_tgt_state && (entry || pend_q);
        launch_l     = (state == ST_GD3);
        k_zero       = !launch_l && (k == '0);
        launch_addr  = launch_l ? l : (k - POS_W'(1));
        tgt_state    = tgt_l_q ? ST_GD3 : ST_GD2;
        abort        = (state != tgt_state);
        rd_field     = mem_rdata[32'(sym)*CNT_W +: CNT_W];
    end

`ifdef OCC_CACHE_EN
    logic               cache_vld_q;
    logic [POS_W-1:0]   cache_addr_q;
    logic [4*CNT_W-1:0] cache_row_q;
    logic               cache_hit;
    logic [CNT_W-1:0]   cache_field;

    // Hit decode against the row last returned by memory
    always_comb begin
        cache_hit   = cache_vld_q && (cache_addr_q == launch_addr);
        cache_field = cache_row_q[32'(sym)*CNT_W +: CNT_W];
    end

    // Cache fill on accepted responses, flush while controller is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_q  <= 1'b0;
            cache_addr_q <= '0;
            cache_row_q  <= '0;
        end else if (state == ST_IDLE) begin
            cache_vld_q  <= 1'b0;
        end else if (fsm_q == S_WAIT && mem_rvalid && !abort) begin
            cache_vld_q  <= 1'b1;
            cache_addr_q <= mem_addr_q;
            cache_row_q  <= mem_rdata;
        end
    end
`endif

    // Fetch FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= S_IDLE;
            prev_state_q <= ST_IDLE;
            tgt_l_q      <= 1'b0;
            pend_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            occ_k_q      <= '0;
            occ_l_q      <= '0;
            done2_q      <= 1'b0;
            done3_q      <= 1'b0;
        end else begin
            prev_state_q <= state;
            done2_q      <= 1'b0;
            done3_q      <= 1'b0;
            if (fsm_q == S_IDLE) begin
                pend_q <= 1'b0;
            end else if (entry) begin
                pend_q <= 1'b1;
            end

            case (fsm_q)
                S_IDLE: begin
                    if (launch) begin
                        tgt_l_q <= launch_l;
                        if (k_zero) begin
                            occ_k_q <= '0;
                            done2_q <= 1'b1;
                            fsm_q   <= S_RESP;
`ifdef OCC_CACHE_EN
                        end else if (cache_hit) begin
                            if (launch_l) begin
                                occ_l_q <= cache_field;
                                done3_q <= 1'b1;
                            end else begin
                                occ_k_q <= cache_field;
                                done2_q <= 1'b1;
                            end
                            fsm_q <= S_RESP;
`endif
                        end else begin
                            mem_addr_q <= launch_addr;
                            mem_req_q  <= 1'b1;
                            fsm_q      <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // A grant in the abort cycle still owes us a response
                    if (abort) begin
                        mem_req_q <= 1'b0;
                        fsm_q     <= mem_gnt ? S_DRAIN : S_IDLE;
                    end else if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        fsm_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (abort) begin
                            fsm_q <= S_IDLE;
                        end else begin
                            if (tgt_l_q) begin
                                occ_l_q <= rd_field;
                                done3_q <= 1'b1;
                            end else begin
                                occ_k_q <= rd_field;
                                done2_q <= 1'b1;
                            end
                            fsm_q <= S_RESP;
                        end
                    end else if (abort) begin
                        fsm_q <= S_DRAIN;
                    end
                end
                S_RESP: begin
                    fsm_q <= S_IDLE;
                end
                S_DRAIN: begin
                    if (mem_rvalid) begin
                        fsm_q <= S_IDLE;
                    end
                end
                default: begin
                    fsm_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_addr       = mem_addr_q;
    assign occ_k          = occ_k_q;
    assign occ_l          = occ_l_q;
    assign is_data_done_2 = done2_q;
    assign is_data_done_3 = done3_q;

endmodule

// File: tb/tb_occ_fetch_unit.sv
// Directed bench for occ_fetch_unit: inputs driven and outputs sampled 1ns after posedge.
module tb_occ_fetch_unit;

    localparam int unsigned POS_W = 16;
    localparam int unsigned CNT_W = 16;

    logic               clk;
    logic               rst;
    logic [2:0]         state;
    logic [POS_W-1:0]   k;
    logic [POS_W-1:0]   l;
    logic [1:0]         sym;
    logic               mem_req;
    logic [POS_W-1:0]   mem_addr;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [4*CNT_W-1:0] mem_rdata;
    logic [CNT_W-1:0]   occ_k;
    logic [CNT_W-1:0]   occ_l;
    logic               is_data_done_2;
    logic               is_data_done_3;

    int tests_run;
    int tests_failed;

    occ_fetch_unit #(.POS_W(POS_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .state          (state),
        .k              (k),
        .l              (l),
        .sym            (sym),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .occ_k          (occ_k),
        .occ_l          (occ_l),
        .is_data_done_2 (is_data_done_2),
        .is_data_done_3 (is_data_done_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; state = 3'b000; k = '0; l = '0; sym = 2'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        tests_run++;
        if ({mem_req, is_data_done_2, is_data_done_3} !== 3'b000) begin
            $display("FAIL reset_ctl: got req/d2/d3=%b expected 000", {mem_req, is_data_done_2, is_data_done_3});
            tests_failed++;
        end
        tests_run++;
        if ({mem_addr, occ_k, occ_l} !== 48'd0) begin
            $display("FAIL reset_data: got addr=%0d occ_k=%0d occ_l=%0d expected 0", mem_addr, occ_k, occ_l);
            tests_failed++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_k();
        state = 3'b010; k = 16'd5; sym = 2'd2;
        tick();
        state = 3'b011;                                   // cycle T
        tests_run++;
        if (mem_req !== 1'b0) begin
            $display("FAIL basic_req_T: got %b expected 0", mem_req); tests_failed++;
        end
        tick();                                           // T+1
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 16'd4) begin
            $display("FAIL basic_req: got req=%b addr=%0d expected req=1 addr=4", mem_req, mem_addr); tests_failed++;
        end
        mem_gnt = 1'b1;
        tick();                                           // T+2
        mem_gnt = 1'b0;
        tests_run++;
        if (mem_req !== 1'b0 || is_data_done_2 !== 1'b0) begin
            $display("FAIL basic_gnt: got req=%b d2=%b expected 0 0", mem_req, is_data_done_2); tests_failed++;
        end
        mem_rvalid = 1'b1; mem_rdata = {16'd9, 16'd7, 16'd4, 16'd1};
        tick();                                           // T+3
        mem_rvalid = 1'b0;
        tests_run++;
        if (is_data_done_2 !== 1'b1 || occ_k !== 16'd7 || is_data_done_3 !== 1'b0) begin
            $display("FAIL basic_done: got d2=%b occ_k=%0d d3=%b expected 1 7 0", is_data_done_2, occ_k, is_data_done_3);
            tests_failed++;
        end
        tick();                                           // T+4
        tests_run++;
        if (is_data_done_2 !== 1'b0) begin
            $display("FAIL basic_pulse: got d2=%b expected 0", is_data_done_2); tests_failed++;
        end
        state = 3'b101;
        tick();
    endtask

    task automatic test_k_zero_then_l();
        state = 3'b010; k = 16'd0; sym = 2'd3;
        tick();
        state = 3'b011;
        tick();                                           // T+1
        tests_run++;
        if (is_data_done_2 !== 1'b1 || occ_k !== 16'd0 || mem_req !== 1'b0) begin
            $display("FAIL kzero_done: got d2=%b occ_k=%0d req=%b expected 1 0 0", is_data_done_2, occ_k, mem_req);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (is_data_done_2 !== 1'b0 || mem_req !== 1'b0) begin
            $display("FAIL kzero_after: got d2=%b req=%b expected 0 0", is_data_done_2, mem_req); tests_failed++;
        end
        state = 3'b100; l = 16'd12; sym = 2'd1;           // GET_DATA_3 entry
        tick();
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 16'd12) begin
            $display("FAIL l_req: got req=%b addr=%0d expected 1 12", mem_req, mem_addr); tests_failed++;
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = {16'd40, 16'd30, 16'd20, 16'd10};
        tick();
        mem_rvalid = 1'b0;
        tests_run++;
        if (is_data_done_3 !== 1'b1 || occ_l !== 16'd20 || is_data_done_2 !== 1'b0 || occ_k !== 16'd0) begin
            $display("FAIL l_done: got d3=%b occ_l=%0d d2=%b occ_k=%0d expected 1 20 0 0",
                     is_data_done_3, occ_l, is_data_done_2, occ_k);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (is_data_done_3 !== 1'b0) begin
            $display("FAIL l_pulse: got d3=%b expected 0", is_data_done_3); tests_failed++;
        end
        state = 3'b101;
        tick();
    endtask

    task automatic test_gnt_delay();
        int pulses;
        pulses = 0;
        state = 3'b010; k = 16'd100; sym = 2'd3;
        tick();
        state = 3'b011;
        tick();                                           // T+1
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (mem_req !== 1'b1 || mem_addr !== 16'd99) begin
                $display("FAIL gnt_hold%0d: got req=%b addr=%0d expected 1 99", i, mem_req, mem_addr);
                tests_failed++;
            end
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = {16'd55, 16'd3, 16'd2, 16'd1};
        for (int i = 0; i < 6; i++) begin
            tick();
            mem_rvalid = 1'b0;
            if (is_data_done_2 === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 1 || occ_k !== 16'd55) begin
            $display("FAIL gnt_delay_done: got pulses=%0d occ_k=%0d expected 1 55", pulses, occ_k); tests_failed++;
        end
        state = 3'b101;
        tick();
    endtask

    task automatic test_abort();
        state = 3'b010; k = 16'd20; sym = 2'd3;
        tick();
        state = 3'b011;
        tick();
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 16'd19) begin
            $display("FAIL abort_req: got req=%b addr=%0d expected 1 19", mem_req, mem_addr); tests_failed++;
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        state = 3'b111;                                   // forced to DONE before rvalid
        tick();
        mem_rvalid = 1'b1; mem_rdata = {16'd77, 16'd66, 16'd65, 16'd64};
        tick();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (is_data_done_2 !== 1'b0 || occ_k !== 16'd55 || mem_req !== 1'b0) begin
                $display("FAIL abort_drain%0d: got d2=%b occ_k=%0d req=%b expected 0 55 0",
                         i, is_data_done_2, occ_k, mem_req);
                tests_failed++;
            end
            tick();
        end
        state = 3'b010; k = 16'd9; sym = 2'd0;
        tick();
        state = 3'b011;
        tick();
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 16'd8) begin
            $display("FAIL abort_refetch_req: got req=%b addr=%0d expected 1 8", mem_req, mem_addr); tests_failed++;
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = {16'd1, 16'd2, 16'd3, 16'd33};
        tick();
        mem_rvalid = 1'b0;
        tests_run++;
        if (is_data_done_2 !== 1'b1 || occ_k !== 16'd33) begin
            $display("FAIL abort_refetch_done: got d2=%b occ_k=%0d expected 1 33", is_data_done_2, occ_k);
            tests_failed++;
        end
    endtask

    // Controller lingers in GET_DATA_2 after the previous done pulse
    task automatic test_no_relaunch();
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (mem_req !== 1'b0 || is_data_done_2 !== 1'b0) begin
                $display("FAIL no_relaunch%0d: got req=%b d2=%b expected 0 0", i, mem_req, is_data_done_2);
                tests_failed++;
            end
        end
        state = 3'b101;
        tick();
    endtask

`ifdef OCC_CACHE_EN
    task automatic test_cache();
        state = 3'b000;
        tick();
        state = 3'b010; k = 16'd12; sym = 2'd2;
        tick();
        state = 3'b011;
        tick();
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 16'd11) begin
            $display("FAIL cache_fill_req: got req=%b addr=%0d expected 1 11", mem_req, mem_addr); tests_failed++;
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = {16'd800, 16'd600, 16'd400, 16'd200};
        tick();
        mem_rvalid = 1'b0;
        tests_run++;
        if (is_data_done_2 !== 1'b1 || occ_k !== 16'd600) begin
            $display("FAIL cache_fill_done: got d2=%b occ_k=%0d expected 1 600", is_data_done_2, occ_k);
            tests_failed++;
        end
        tick();
        state = 3'b100; l = 16'd11; sym = 2'd3;
        tick();                                           // T+1
        tests_run++;
        if (is_data_done_3 !== 1'b1 || mem_req !== 1'b0 || occ_l !== 16'd800) begin
            $display("FAIL cache_hit: got d3=%b req=%b occ_l=%0d expected 1 0 800", is_data_done_3, mem_req, occ_l);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (is_data_done_3 !== 1'b0 || mem_req !== 1'b0) begin
            $display("FAIL cache_hit_after: got d3=%b req=%b expected 0 0", is_data_done_3, mem_req);
            tests_failed++;
        end
        state = 3'b101;
        tick();
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic_k();
        test_k_zero_then_l();
        test_gnt_delay();
        test_abort();
        test_no_relaunch();
`ifdef OCC_CACHE_EN
        test_cache();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
